imm_encoder: RTL and testbench

Streaming immediate encoder, the inverse of the core's immediate extender. It takes a 32-bit constant and a requested `imm_src` format and produces the 26-bit raw instruction immediate field. Feeding that field through the extender with the emitted `src_out` must return the original constant. When the constant does not fit the requested format, it either flags the error or splits the constant into an upper/lower instruction pair. The block sits in the instruction-generation path (loader / code-patch unit) ahead of the instruction word assembler.

---
 rtl/imm_encoder_if.sv | 31 +++
 rtl/imm_encoder.sv | 152 +++++++++++++++
 tb/tb_imm_encoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_if.sv
// Request/response bundle for the streaming immediate encoder.
// Request side : in_valid, in_ready, in_imm[31:0], in_src[3:0], in_split_en
// Response side: out_valid, out_ready, out_field[25:0], out_src[3:0], out_last,
//                out_err_range, out_err_align
// master: the agent that issues requests and consumes beats; slave: the encoder.
interface imm_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_imm;
   logic [3:0]  in_src;
   logic        in_split_en;
   logic        out_valid;
   logic        out_ready;
   logic [25:0] out_field;
   logic [3:0]  out_src;
   logic        out_last;
   logic        out_err_range;
   logic        out_err_align;

   modport master (
      output in_valid, in_imm, in_src, in_split_en, out_ready,
      input  in_ready, out_valid, out_field, out_src, out_last,
             out_err_range, out_err_align
   );

   modport slave (
      input  in_valid, in_imm, in_src, in_split_en, out_ready,
      output in_ready, out_valid, out_field, out_src, out_last,
             out_err_range, out_err_align
   );
endinterface

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: inverse of the immediate extender. Packs a
// 32-bit constant into the 26-bit raw field for the requested imm_src, or
// splits a non-representable constant into a d-upper / d-lower beat pair.
// Ports:
//   clk    - clock, all state on rising edge
//   rst    - synchronous active-high reset
//   enc_if - imm_encoder_if.slave request/response bundle
module imm_encoder (
   input  logic          clk,
   input  logic          rst,
   imm_encoder_if.slave  enc_if
);
   localparam int unsigned FieldW = 26;
   localparam int unsigned LoW    = 11;

   typedef enum logic {IDLE, LO_PEND} state_e;

   state_e              state_q, state_d;
   logic [LoW-1:0]      lo_q, lo_d;
   logic                out_valid_q, out_valid_d;
   logic [FieldW-1:0]   out_field_q, out_field_d;
   logic [3:0]          out_src_q, out_src_d;
   logic                out_last_q, out_last_d;
   logic                err_range_q, err_range_d;
   logic                err_align_q, err_align_d;

   logic                in_ready_c;
   logic                accept_c;
   logic [FieldW-1:0]   enc_field_c;
   logic                fits_c;
   logic                align_ok_c;
   logic                split_c;
   logic                sext_c;
   logic [31:0]         imm_c;

   assign imm_c  = enc_if.in_imm;
   assign sext_c = ~enc_if.in_src[0];

   // Format encode and representability check for the incoming request.
   always_comb begin
      enc_field_c = '0;
      fits_c      = 1'b0;
      align_ok_c  = 1'b1;
      unique case (enc_if.in_src[3:1])
         3'b000: begin
            enc_field_c = {imm_c[15:0], 10'b0};
            fits_c = sext_c ? (&imm_c[31:15] | ~|imm_c[31:15]) : ~|imm_c[31:16];
         end
         3'b010: begin
            enc_field_c = {imm_c[15:5], 10'b0, imm_c[4:0]};
            fits_c = sext_c ? (&imm_c[31:15] | ~|imm_c[31:15]) : ~|imm_c[31:16];
         end
         3'b100: begin
            enc_field_c = {imm_c[17:7], 10'b0, imm_c[6:2]};
            fits_c = sext_c ? (&imm_c[31:17] | ~|imm_c[31:17]) : ~|imm_c[31:18];
            align_ok_c = ~|imm_c[1:0];
         end
         3'b110: begin
            enc_field_c = {imm_c[20:0], 5'b0};
            fits_c = sext_c ? (&imm_c[31:20] | ~|imm_c[31:20]) : ~|imm_c[31:21];
         end
         default: begin
            // d upper: only the high 21 bits are carried
            enc_field_c = {imm_c[31:11], 5'b0};
            fits_c = ~|imm_c[10:0];
         end
      endcase
   end

   assign split_c = enc_if.in_split_en & ~(fits_c & align_ok_c);

   // Next-state and output-register load; outputs hold while stalled.
   always_comb begin
      state_d     = state_q;
      lo_d        = lo_q;
      out_valid_d = out_valid_q & ~enc_if.out_ready;
      out_field_d = out_field_q;
      out_src_d   = out_src_q;
      out_last_d  = out_last_q;
      err_range_d = err_range_q;
      err_align_d = err_align_q;
      in_ready_c  = 1'b0;
      accept_c    = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready_c = ~out_valid_q | enc_if.out_ready;
            accept_c   = enc_if.in_valid & in_ready_c;
            if (accept_c) begin
               out_valid_d = 1'b1;
               if (split_c) begin
                  out_field_d = {imm_c[31:11], 5'b0};
                  out_src_d   = 4'b1110;
                  out_last_d  = 1'b0;
                  err_range_d = 1'b0;
                  err_align_d = 1'b0;
                  lo_d        = imm_c[10:0];
                  state_d     = LO_PEND;
               end else begin
                  out_field_d = enc_field_c;
                  out_src_d   = enc_if.in_src;
                  out_last_d  = 1'b1;
                  err_range_d = ~fits_c;
                  err_align_d = ~align_ok_c;
               end
            end
         end
         LO_PEND: begin
            // beat 1 is always valid here; load beat 2 when it is taken
            if (enc_if.out_ready) begin
               out_valid_d = 1'b1;
               out_field_d = {10'b0, lo_q, 5'b0};
               out_src_d   = 4'b1101;
               out_last_d  = 1'b1;
               err_range_d = 1'b0;
               err_align_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lo_q        <= '0;
         out_valid_q <= 1'b0;
         out_field_q <= '0;
         out_src_q   <= '0;
         out_last_q  <= 1'b0;
         err_range_q <= 1'b0;
         err_align_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lo_q        <= lo_d;
         out_valid_q <= out_valid_d;
         out_field_q <= out_field_d;
         out_src_q   <= out_src_d;
         out_last_q  <= out_last_d;
         err_range_q <= err_range_d;
         err_align_q <= err_align_d;
      end
   end

   assign enc_if.in_ready      = in_ready_c;
   assign enc_if.out_valid     = out_valid_q;
   assign enc_if.out_field     = out_field_q;
   assign enc_if.out_src       = out_src_q;
   assign enc_if.out_last      = out_last_q;
   assign enc_if.out_err_range = err_range_q;
   assign enc_if.out_err_align = err_align_q;
endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder with an independent extender model for
// round-trip decoding of every emitted beat.
module tb_imm_encoder;
   logic clk;
   logic rst;
   int   errors;
   int   checks;
   logic [31:0] up_val;
   logic [25:0] hold_field;

   imm_encoder_if bus ();

   imm_encoder u_dut (
      .clk    (clk),
      .rst    (rst),
      .enc_if (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   // Reference extender: field + imm_src back to a 32-bit constant.
   function automatic logic [31:0] ext(input logic [25:0] f, input logic [3:0] src);
      logic        s;
      logic [15:0] v16;
      logic [17:0] v18;
      logic [20:0] v21;
      s   = ~src[0];
      v16 = {f[25:15], f[4:0]};
      v18 = {f[25:15], f[4:0], 2'b00};
      v21 = f[25:5];
      case (src[3:1])
         3'b000:  ext = s ? {{16{f[25]}}, f[25:10]} : {16'b0, f[25:10]};
         3'b010:  ext = s ? {{16{v16[15]}}, v16} : {16'b0, v16};
         3'b100:  ext = s ? {{14{v18[17]}}, v18} : {14'b0, v18};
         3'b110:  ext = s ? {{11{v21[20]}}, v21} : {11'b0, v21};
         default: ext = {v21, 11'b0};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] imm, input logic [3:0] src, input logic split);
      bus.in_valid    = 1'b1;
      bus.in_imm      = imm;
      bus.in_src      = src;
      bus.in_split_en = split;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.in_valid    = 1'b0;
      bus.in_imm      = '0;
      bus.in_src      = '0;
      bus.in_split_en = 1'b0;
      bus.out_ready   = 1'b1;
      step();
      step();
      chk("rst_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_field", 32'(bus.out_field), 32'h0);
      chk("rst_src",   32'(bus.out_src),   32'h0);
      chk("rst_last",  32'(bus.out_last),  32'h0);
      chk("rst_errs",  32'({bus.out_err_range, bus.out_err_align}), 32'h0);
      rst = 1'b0;
      step();
      chk("post_rst_ready", 32'(bus.in_ready), 32'h1);

      // sign-extended b/f
      drive(32'hFFFF_FF80, 4'b0000, 1'b0);
      #1 chk("bf_in_ready", 32'(bus.in_ready), 32'h1);
      step();
      chk("bf_valid", 32'(bus.out_valid), 32'h1);
      chk("bf_field", 32'(bus.out_field), 32'h03FE_0000);
      chk("bf_src",   32'(bus.out_src),   32'h0);
      chk("bf_last",  32'(bus.out_last),  32'h1);
      chk("bf_errs",  32'({bus.out_err_range, bus.out_err_align}), 32'h0);
      chk("bf_rt",    ext(bus.out_field, bus.out_src), 32'hFFFF_FF80);

      // range error, back-to-back with the previous beat
      drive(32'h0001_0000, 4'b0001, 1'b0);
      step();
      chk("rng_valid", 32'(bus.out_valid),     32'h1);
      chk("rng_err",   32'(bus.out_err_range), 32'h1);
      chk("rng_align", 32'(bus.out_err_align), 32'h0);
      chk("rng_field", 32'(bus.out_field),     32'h0);
      chk("rng_last",  32'(bus.out_last),      32'h1);

      // alignment error, format g
      drive(32'h0000_0006, 4'b1000, 1'b0);
      step();
      chk("aln_err",   32'(bus.out_err_align), 32'h1);
      chk("aln_range", 32'(bus.out_err_range), 32'h0);
      chk("aln_field", 32'(bus.out_field),     32'h1);
      chk("aln_src",   32'(bus.out_src),       32'h8);

      // format c, zero-extended
      drive(32'h0000_7FE3, 4'b0101, 1'b0);
      step();
      chk("c_field", 32'(bus.out_field), 32'h01FF_8003);
      chk("c_errs",  32'({bus.out_err_range, bus.out_err_align}), 32'h0);
      chk("c_rt",    ext(bus.out_field, bus.out_src), 32'h0000_7FE3);

      // d upper, representable
      drive(32'hABCD_E800, 4'b0111, 1'b0);
      step();
      chk("du_field", 32'(bus.out_field), 32'h02AF_37A0);
      chk("du_src",   32'(bus.out_src),   32'h7);
      chk("du_errs",  32'({bus.out_err_range, bus.out_err_align}), 32'h0);
      chk("du_rt",    ext(bus.out_field, bus.out_src), 32'hABCD_E800);

      // split with 3 cycles of backpressure on beat 1
      drive(32'h1234_5678, 4'b1100, 1'b1);
      step();
      bus.out_ready = 1'b0;
      drive(32'hDEAD_BEEF, 4'b0000, 1'b0);   // must be ignored
      chk("sp1_valid", 32'(bus.out_valid), 32'h1);
      chk("sp1_src",   32'(bus.out_src),   32'hE);
      chk("sp1_field", 32'(bus.out_field), 32'h0048_D140);
      chk("sp1_last",  32'(bus.out_last),  32'h0);
      chk("sp1_errs",  32'({bus.out_err_range, bus.out_err_align}), 32'h0);
      chk("sp1_ready", 32'(bus.in_ready),  32'h0);
      up_val = ext(bus.out_field, bus.out_src);
      hold_field = bus.out_field;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_valid", 32'(bus.out_valid), 32'h1);
         chk("bp_field", 32'(bus.out_field), 32'(hold_field));
         chk("bp_src",   32'(bus.out_src),   32'hE);
         chk("bp_last",  32'(bus.out_last),  32'h0);
         chk("bp_ready", 32'(bus.in_ready),  32'h0);
      end
      bus.out_ready = 1'b1;
      #1 chk("sp1_ready_or", 32'(bus.in_ready), 32'h0);
      step();
      bus.in_valid = 1'b0;
      chk("sp2_valid", 32'(bus.out_valid), 32'h1);
      chk("sp2_src",   32'(bus.out_src),   32'hD);
      chk("sp2_field", 32'(bus.out_field), 32'h0000_CF00);
      chk("sp2_last",  32'(bus.out_last),  32'h1);
      chk("sp_rt",     up_val | ext(bus.out_field, bus.out_src), 32'h1234_5678);
      step();
      chk("sp_drain", 32'(bus.out_valid), 32'h0);

      // reset while beat 1 is pending
      bus.out_ready = 1'b0;
      drive(32'h1234_5678, 4'b1100, 1'b1);
      step();
      bus.in_valid = 1'b0;
      chk("rp_beat1", 32'(bus.out_src), 32'hE);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rp_valid", 32'(bus.out_valid), 32'h0);
      chk("rp_ready", 32'(bus.in_ready),  32'h1);
      bus.out_ready = 1'b1;
      step();
      chk("rp_no_beat2", 32'(bus.out_valid), 32'h0);
      drive(32'hFFFF_FF80, 4'b0000, 1'b0);
      step();
      bus.in_valid = 1'b0;
      chk("rp_after_valid", 32'(bus.out_valid), 32'h1);
      chk("rp_after_field", 32'(bus.out_field), 32'h03FE_0000);
      chk("rp_after_last",  32'(bus.out_last),  32'h1);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
